datamover_cmd_arbiter: RTL and testbench
========================================

DATAMOVER_CMD_ARBITER -- requirements
Module: datamover_cmd_arbiter

Interface
REQ-001 Parameter C_MAX_OUTSTANDING, default 4, sets the maximum number of issued-but-unacknowledged commands per requester (legal range 1..8).
REQ-002 m_axi_aclk  input  1  single clock; all logic is rising-edge.
REQ-003 m_axi_aresetn  input  1  reset, asynchronous assert, active-low.
REQ-004 s0_axis_cmd_tdata/tvalid/tready  in/in/out  72/1/1  requester 0 S2MM command stream.
REQ-005 s1_axis_cmd_tdata/tvalid/tready  in/in/out  72/1/1  requester 1 S2MM command stream.
REQ-006 m_axis_s2mm_cmd_tdata/tvalid/tready  out/out/in  72/1/1  command stream to the DataMover.
REQ-007 s_axis_s2mm_sts_tdata/tvalid/tready  in/in/out  8/1/1  status stream from the DataMover.
REQ-008 m0_axis_sts_tdata/tvalid/tready  out/out/in  8/1/1  status routed to requester 0.
REQ-009 m1_axis_sts_tdata/tvalid/tready  out/out/in  8/1/1  status routed to requester 1.
REQ-010 tag_error  output  1  sticky flag: status received with an unexpected tag.

Function
REQ-011 States: IDLE (no command held), HOLD (command registered on m_axis_s2mm_cmd, waiting for tready).
REQ-012 In IDLE, requester n is eligible when sN_tvalid=1 and outstanding[n] < C_MAX_OUTSTANDING.
REQ-013 Arbitration is round-robin: with both eligible, the requester not granted last wins; last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-014 On grant, sN_tready pulses for exactly that cycle, and the command is registered to m_axis_s2mm_cmd_tdata with tvalid=1 on the next cycle (state HOLD); the non-granted tready stays 0.
REQ-015 The registered command equals the input except tag bits [67:64] = {n, seq[n][2:0]}; seq[n] increments mod 8 on each grant to n.
REQ-016 In HOLD, tdata and tvalid remain stable until tvalid&tready; on that cycle the state returns to IDLE and no grant is made (one idle cycle between commands; sustained throughput 1 command per 2 cycles).
REQ-017 outstanding[n] increments on grant to n; decrements on status handshake routed to n; unchanged if both occur in the same cycle; never exceeds C_MAX_OUTSTANDING nor goes below 0.
REQ-018 Status routing uses s_axis_s2mm_sts_tdata[3]; tdata is passed through unmodified into a one-entry output register per requester.
REQ-019 s_axis_s2mm_sts_tready = 1 when the target register (selected by tdata[3]) is empty, or will empty this cycle (mN_tvalid&mN_tready); otherwise 0.
REQ-020 mN_axis_sts_tvalid asserts the cycle after the input handshake and holds with stable tdata until mN_tready.
REQ-021 Per requester, expected status tag advances mod 8 on each routed status; status whose tdata[2:0] differs from the expected value, or that arrives while outstanding[n]=0, sets tag_error. The status is still delivered and the counter is not decremented below 0.
REQ-022 Command issue and status return operate independently and may handshake in the same cycle.

Reset
REQ-023 While m_axi_aresetn=0: state IDLE; all tvalid and tready outputs 0; tdata registers 0; outstanding, seq and expected tags 0; last-grant pointer 1; tag_error 0.
REQ-024 Reset asserted mid-HOLD or mid-status discards the held beat; no partial beat is presented after release.
REQ-025 The first grant may occur on the first clock edge after reset is released.

Verification
REQ-026 Reset, then s0 and s1 both valid continuously with m_tready=1 -> grants alternate 0,1,0,1; tags 0x0,0x8,0x1,0x9; a new tvalid every 2 cycles.
REQ-027 C_MAX_OUTSTANDING=4, s0 always valid, no status returned -> exactly 4 commands issued, then s0_tready stays 0; one status with tag 0x0 -> exactly one more command issued, with tag 0x4.
REQ-028 m_axis_s2mm_cmd_tready held 0 for 10 cycles in HOLD -> tdata and tvalid are stable throughout; s0_tready and s1_tready stay 0.
REQ-029 Status 0x88 delivered while m1_tready=0 -> m1 tvalid held with tdata 0x88; a second status for requester 1 sees s_sts_tready=0; a status 0x80 for requester 0 is accepted in the same window.
REQ-030 Status tag 0x2 while requester 0 expects 0x0 -> tag_error=1 and stays 1 until reset; the status is delivered on m0.
REQ-031 Reset asserted while in HOLD -> m_axis_s2mm_cmd_tvalid=0 asynchronously; after release, outstanding counts and tags restart from 0.

Source files
------------

// File: rtl/datamover_cmd_arbiter_if.sv
// Generic valid/ready stream bundle shared by the command and status paths of
// the datamover command arbiter.
interface datamover_cmd_arbiter_if #(
    parameter int W = 72
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/datamover_cmd_arbiter.sv
// Two-requester round-robin arbiter in front of a DataMover S2MM command port,
// with tag stamping, outstanding-command limiting and status return routing.
module datamover_cmd_arbiter #(
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_aresetn,
    datamover_cmd_arbiter_if.slave  s0_axis_cmd,
    datamover_cmd_arbiter_if.slave  s1_axis_cmd,
    datamover_cmd_arbiter_if.master m_axis_s2mm_cmd,
    datamover_cmd_arbiter_if.slave  s_axis_s2mm_sts,
    datamover_cmd_arbiter_if.master m0_axis_sts,
    datamover_cmd_arbiter_if.master m1_axis_sts,
    output logic                    tag_error
);

    // state | meaning
    // IDLE  | no command held; a grant may be made this cycle
    // HOLD  | command registered on m_axis_s2mm_cmd, waiting for tready
    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state_q;
    logic [71:0] cmd_data_q;
    logic        cmd_valid_q;
    logic        last_q;
    logic [2:0]  seq_q [2];

    logic [3:0]  outst_q [2];
    logic [2:0]  exp_q [2];
    logic [7:0]  sts_data_q [2];
    logic        sts_valid_q [2];
    logic        tag_error_q;

    logic [1:0]  elig;
    logic [1:0]  gnt;
    logic        win;
    logic [71:0] cmd_d;
    logic        sts_sel;
    logic        sts_rdy;
    logic [1:0]  out_hs;
    logic [1:0]  sts_rt;
    logic        unused_tag_bits;

    assign unused_tag_bits = ^{s0_axis_cmd.tdata[67:64], s1_axis_cmd.tdata[67:64]};

    always_comb begin
        elig[0] = s0_axis_cmd.tvalid && (outst_q[0] < 4'(C_MAX_OUTSTANDING));
        elig[1] = s1_axis_cmd.tvalid && (outst_q[1] < 4'(C_MAX_OUTSTANDING));
        gnt     = 2'b00;
        if (m_axi_aresetn && (state_q == IDLE)) begin
            if (elig == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = elig;
            end
        end
        win   = gnt[1];
        cmd_d = win ? s1_axis_cmd.tdata : s0_axis_cmd.tdata;
        cmd_d[67:64] = {win, seq_q[win]};
    end

    always_comb begin
        out_hs[0] = sts_valid_q[0] && m0_axis_sts.tready;
        out_hs[1] = sts_valid_q[1] && m1_axis_sts.tready;
        sts_sel   = s_axis_s2mm_sts.tdata[3];
        sts_rdy   = m_axi_aresetn && (!sts_valid_q[sts_sel] || out_hs[sts_sel]);
        sts_rt[0] = s_axis_s2mm_sts.tvalid && sts_rdy && !sts_sel;
        sts_rt[1] = s_axis_s2mm_sts.tvalid && sts_rdy && sts_sel;
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= IDLE;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            last_q      <= 1'b1;
            seq_q[0]    <= '0;
            seq_q[1]    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        cmd_data_q  <= cmd_d;
                        cmd_valid_q <= 1'b1;
                        last_q      <= win;
                        seq_q[win]  <= seq_q[win] + 3'd1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (m_axis_s2mm_cmd.tready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A status arriving with nothing outstanding is still delivered, but flagged
    // and never allowed to wrap the counter below zero.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            for (int n = 0; n < 2; n++) begin
                outst_q[n]     <= '0;
                exp_q[n]       <= '0;
                sts_data_q[n]  <= '0;
                sts_valid_q[n] <= 1'b0;
            end
            tag_error_q <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (gnt[n] && !(sts_rt[n] && (outst_q[n] != 4'd0))) begin
                    outst_q[n] <= outst_q[n] + 4'd1;
                end else if (!gnt[n] && sts_rt[n] && (outst_q[n] != 4'd0)) begin
                    outst_q[n] <= outst_q[n] - 4'd1;
                end
                if (sts_rt[n]) begin
                    sts_data_q[n]  <= s_axis_s2mm_sts.tdata;
                    sts_valid_q[n] <= 1'b1;
                    exp_q[n]       <= exp_q[n] + 3'd1;
                    if ((s_axis_s2mm_sts.tdata[2:0] != exp_q[n]) || (outst_q[n] == 4'd0)) begin
                        tag_error_q <= 1'b1;
                    end
                end else if (out_hs[n]) begin
                    sts_valid_q[n] <= 1'b0;
                end
            end
        end
    end

    assign s0_axis_cmd.tready     = gnt[0];
    assign s1_axis_cmd.tready     = gnt[1];
    assign m_axis_s2mm_cmd.tdata  = cmd_data_q;
    assign m_axis_s2mm_cmd.tvalid = cmd_valid_q;
    assign s_axis_s2mm_sts.tready = sts_rdy;
    assign m0_axis_sts.tdata      = sts_data_q[0];
    assign m0_axis_sts.tvalid     = sts_valid_q[0];
    assign m1_axis_sts.tdata      = sts_data_q[1];
    assign m1_axis_sts.tvalid     = sts_valid_q[1];
    assign tag_error              = tag_error_q;

endmodule

// File: tb/tb_datamover_cmd_arbiter.sv
// Bench for datamover_cmd_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_datamover_cmd_arbiter;

    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tag_error;

    always #5 clk = ~clk;

    datamover_cmd_arbiter_if #(.W(72)) s0_if ();
    datamover_cmd_arbiter_if #(.W(72)) s1_if ();
    datamover_cmd_arbiter_if #(.W(72)) mc_if ();
    datamover_cmd_arbiter_if #(.W(8))  ss_if ();
    datamover_cmd_arbiter_if #(.W(8))  m0_if ();
    datamover_cmd_arbiter_if #(.W(8))  m1_if ();

    datamover_cmd_arbiter #(.C_MAX_OUTSTANDING(MAXO)) dut (
        .m_axi_aclk      (clk),
        .m_axi_aresetn   (rst_n),
        .s0_axis_cmd     (s0_if),
        .s1_axis_cmd     (s1_if),
        .m_axis_s2mm_cmd (mc_if),
        .s_axis_s2mm_sts (ss_if),
        .m0_axis_sts     (m0_if),
        .m1_axis_sts     (m1_if),
        .tag_error       (tag_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          hold;
    logic [71:0] held;
    int          last_gnt;
    int          seq [2];
    int          exp_tag [2];
    int          out_cnt [2];
    bit          buf_v [2];
    logic [7:0]  buf_d [2];
    bit          terr;

    int          n_issued;
    logic [3:0]  last_tag;
    logic [3:0]  tags [$];

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hold = 0;
        held = '0;
        last_gnt = 1;
        terr = 0;
        for (int n = 0; n < 2; n++) begin
            seq[n] = 0;
            exp_tag[n] = 0;
            out_cnt[n] = 0;
            buf_v[n] = 0;
            buf_d[n] = '0;
        end
    endtask

    task automatic drive(input bit s0v, input bit s1v, input bit mr, input bit stv,
                         input logic [7:0] std, input bit m0r, input bit m1r);
        s0_if.tvalid = s0v;
        s1_if.tvalid = s1v;
        s0_if.tdata  = {8'($urandom), 32'($urandom), 32'($urandom)};
        s1_if.tdata  = {8'($urandom), 32'($urandom), 32'($urandom)};
        mc_if.tready = mr;
        ss_if.tvalid = stv;
        ss_if.tdata  = std;
        m0_if.tready = m0r;
        m1_if.tready = m1r;
    endtask

    // Called at a falling edge with inputs already applied; checks, advances
    // the model across the next rising edge and returns at the next falling edge.
    task automatic cycle();
        int g;
        int sel;
        bit sr;
        bit e0, e1;
        logic [71:0] cmd;
        #1;
        g = -1;
        e0 = s0_if.tvalid && (out_cnt[0] < MAXO);
        e1 = s1_if.tvalid && (out_cnt[1] < MAXO);
        if (!hold) begin
            if (e0 && e1) g = (last_gnt == 1) ? 0 : 1;
            else if (e0) g = 0;
            else if (e1) g = 1;
        end
        sel = int'(ss_if.tdata[3]);
        sr  = !buf_v[sel] || ((sel == 1) ? m1_if.tready : m0_if.tready);

        chk("s0_tready", s0_if.tready, g == 0);
        chk("s1_tready", s1_if.tready, g == 1);
        chk("cmd_tvalid", mc_if.tvalid, hold);
        if (hold) chk("cmd_tdata", mc_if.tdata, held);
        chk("sts_tready", ss_if.tready, sr);
        chk("m0_tvalid", m0_if.tvalid, buf_v[0]);
        if (buf_v[0]) chk("m0_tdata", m0_if.tdata, buf_d[0]);
        chk("m1_tvalid", m1_if.tvalid, buf_v[1]);
        if (buf_v[1]) chk("m1_tdata", m1_if.tdata, buf_d[1]);
        chk("tag_error", tag_error, terr);

        if (mc_if.tvalid && mc_if.tready) begin
            n_issued++;
            last_tag = mc_if.tdata[67:64];
            tags.push_back(mc_if.tdata[67:64]);
        end

        if (buf_v[0] && m0_if.tready) buf_v[0] = 0;
        if (buf_v[1] && m1_if.tready) buf_v[1] = 0;
        if (ss_if.tvalid && sr) begin
            if ((int'(ss_if.tdata[2:0]) != exp_tag[sel]) || (out_cnt[sel] == 0)) terr = 1;
            exp_tag[sel] = (exp_tag[sel] + 1) % 8;
            if (out_cnt[sel] > 0) out_cnt[sel]--;
            buf_v[sel] = 1;
            buf_d[sel] = ss_if.tdata;
        end

        if (hold) begin
            if (mc_if.tready) hold = 0;
        end else if (g >= 0) begin
            cmd = (g == 1) ? s1_if.tdata : s0_if.tdata;
            cmd[67:64] = {g[0], 3'(seq[g])};
            held = cmd;
            hold = 1;
            last_gnt = g;
            seq[g] = (seq[g] + 1) % 8;
            out_cnt[g]++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1, 1, 1, 1, 8'h00, 1, 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_s0_tready", s0_if.tready, 1'b0);
        chk("rst_s1_tready", s1_if.tready, 1'b0);
        chk("rst_cmd_tvalid", mc_if.tvalid, 1'b0);
        chk("rst_cmd_tdata", mc_if.tdata, 72'h0);
        chk("rst_sts_tready", ss_if.tready, 1'b0);
        chk("rst_m0_tvalid", m0_if.tvalid, 1'b0);
        chk("rst_m1_tvalid", m1_if.tvalid, 1'b0);
        chk("rst_tag_error", tag_error, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 0, 8'h00, 0, 0);
        rst_n = 1'b1;
        model_reset();
        n_issued = 0;
        tags.delete();
    endtask

    initial begin
        logic [3:0] exp_rr [4];
        exp_rr = '{4'h0, 4'h8, 4'h1, 4'h9};
        model_reset();
        do_reset();

        // alternating grants under continuous contention
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 0, 8'h00, 1, 1);
            cycle();
        end
        chk("rr_count", 72'(tags.size()), 72'd4);
        for (int i = 0; i < 4 && i < tags.size(); i++) chk("rr_tag", tags[i], exp_rr[i]);

        // outstanding limit
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 1, 0, 8'h00, 1, 1);
            cycle();
        end
        chk("max_issue", 72'(n_issued), 72'(MAXO));
        drive(1, 0, 1, 1, 8'h00, 1, 1);
        cycle();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 1, 0, 8'h00, 1, 1);
            cycle();
        end
        chk("refill_issue", 72'(n_issued), 72'(MAXO + 1));
        chk("refill_tag", last_tag, 4'h4);

        // backpressure while holding
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(1, 1, 0, 0, 8'h00, 1, 1);
            cycle();
        end
        chk("hold_issue", 72'(n_issued), 72'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0, 8'h00, 1, 1);
            cycle();
        end
        chk("hold_release", 72'(n_issued), 72'd1);

        // status backpressure on requester 1 with requester 0 still accepted
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 0, 8'h00, 1, 1);
            cycle();
        end
        drive(0, 0, 1, 1, 8'h88, 1, 0);
        cycle();
        drive(0, 0, 1, 1, 8'h89, 1, 0);
        #1 chk("sts1_blocked", ss_if.tready, 1'b0);
        cycle();
        drive(0, 0, 1, 1, 8'h80, 0, 0);
        #1 chk("sts0_accepted", ss_if.tready, 1'b1);
        cycle();
        drive(0, 0, 1, 0, 8'h00, 0, 0);
        #1;
        chk("m1_held_valid", m1_if.tvalid, 1'b1);
        chk("m1_held_data", m1_if.tdata, 8'h88);
        chk("m0_data", m0_if.tdata, 8'h80);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 8'h00, 1, 1);
            cycle();
        end

        // unexpected tag is sticky and still delivered
        do_reset();
        drive(1, 0, 1, 0, 8'h00, 1, 1);
        cycle();
        drive(0, 0, 1, 0, 8'h00, 1, 1);
        cycle();
        drive(0, 0, 1, 1, 8'h02, 0, 1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 8'h00, 0, 1);
            cycle();
        end
        chk("tag_err_sticky", tag_error, 1'b1);
        chk("tag_err_delivered", m0_if.tdata, 8'h02);

        // reset while holding
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 8'h00, 1, 1);
            cycle();
        end
        #2 rst_n = 1'b0;
        #1 chk("async_rst_tvalid", mc_if.tvalid, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 0, 8'h00, 1, 1);
            cycle();
        end
        chk("post_rst_issue", 72'(tags.size()), 72'd2);
        if (tags.size() > 0) chk("post_rst_tag", tags[0], 4'h0);

        // random traffic
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            for (int i = 0; i < 500; i++) begin
                int s;
                bit stv;
                logic [7:0] std;
                s = int'($urandom_range(0, 1));
                std = {4'($urandom), s[0], 3'(exp_tag[s])};
                stv = (out_cnt[s] > 0) && ($urandom_range(0, 9) < 5);
                if ($urandom_range(0, 39) == 0) begin
                    stv = 1;
                    std[2:0] = 3'($urandom);
                end
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                      $urandom_range(0, 3) != 0, stv, std,
                      $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
